// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM state encoding, bus-level ACK/RW constants
// and the address-match helper.
package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ADDR      = 3'd1,
      ST_ADDR_ACK  = 3'd2,
      ST_WRITE     = 3'd3,
      ST_WRITE_ACK = 3'd4,
      ST_READ      = 3'd5,
      ST_READ_ACK  = 3'd6,
      ST_IGNORE    = 3'd7
   } i2c_state_e;

   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;
   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;

   // The general-call address is never acknowledged, even if configured as our own.
   function automatic logic addr_match(input logic [6:0] addr, input logic [6:0] own);
      return (addr == own) && (addr != 7'h00);
   endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizer followed by one edge-detect stage; produces bus edge
// and START/STOP events in the system clock domain.
module i2c_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic n_rst,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_s
);

   logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
   logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
   logic                   scl_prev_q, scl_prev_d;
   logic                   sda_prev_q, sda_prev_d;
   logic                   scl_now, sda_now;

   assign scl_now = scl_sync_q[SYNC_STAGES-1];
   assign sda_now = sda_sync_q[SYNC_STAGES-1];

   always_comb begin
      scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_d = scl_now;
      sda_prev_d = sda_now;
   end

   // Reset to the idle bus level (both high) so release from reset never fakes an edge.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         scl_prev_q <= scl_prev_d;
         sda_prev_q <= sda_prev_d;
      end
   end

   assign scl_rise  = scl_now & ~scl_prev_q;
   assign scl_fall  = ~scl_now & scl_prev_q;
   assign start_det = scl_now & scl_prev_q & sda_prev_q & ~sda_now;
   assign stop_det  = scl_now & scl_prev_q & ~sda_prev_q & sda_now;
   assign sda_s     = sda_now;

endmodule

// File: rtl/i2c_target.sv
// I2C target endpoint: address match, write reception and read serving on an
// open-drain SDA line, with one-clock strobes toward the local side.
import i2c_pkg::*;

module i2c_target #(
   parameter logic [6:0] SLAVE_ADDR  = 7'h54,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       scl,
   inout  wire        sda,
   input  logic [7:0] tx_data,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       tx_req,
   output logic       addr_hit,
   output logic       busy
);

   logic scl_rise, scl_fall, start_det, stop_det, sda_s;

   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
      .clk       (clk),
      .n_rst     (n_rst),
      .scl_i     (scl),
      .sda_i     (sda),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det),
      .sda_s     (sda_s)
   );

   i2c_state_e state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       done_q, done_d;
   logic       rw_q, rw_d;
   logic       sda_oe_q, sda_oe_d;
   logic       addr_hit_q, addr_hit_d;
   logic       busy_q, busy_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       tx_req_c;

   // Local-side strobes carry no handshake: rx_valid marks one clock in which rx_data
   // is new; tx_req marks the clock in which tx_data is loaded into the shifter.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      done_d     = done_q;
      rw_d       = rw_q;
      sda_oe_d   = sda_oe_q;
      addr_hit_d = addr_hit_q;
      busy_d     = busy_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      tx_req_c   = 1'b0;

      case (state_q)
         ST_IDLE: sda_oe_d = 1'b0;
         ST_ADDR: begin
            if (scl_rise) begin
               shift_d   = {shift_q[6:0], sda_s};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) done_d = 1'b1;
            end else if (scl_fall && done_q) begin
               done_d = 1'b0;
               rw_d   = shift_q[0];
               if (addr_match(shift_q[7:1], SLAVE_ADDR)) begin
                  state_d    = ST_ADDR_ACK;
                  sda_oe_d   = ~I2C_ACK;
                  addr_hit_d = 1'b1;
               end else begin
                  state_d = ST_IGNORE;
               end
            end
         end
         ST_ADDR_ACK: begin
            if (scl_fall) begin
               bit_cnt_d = 3'd0;
               if (rw_q == RW_READ) begin
                  tx_req_c = 1'b1;
                  shift_d  = tx_data;
                  sda_oe_d = ~tx_data[7];
                  state_d  = ST_READ;
               end else begin
                  sda_oe_d = 1'b0;
                  state_d  = ST_WRITE;
               end
            end
         end
         ST_WRITE: begin
            if (scl_rise) begin
               shift_d   = {shift_q[6:0], sda_s};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  rx_data_d  = {shift_q[6:0], sda_s};
                  rx_valid_d = 1'b1;
                  done_d     = 1'b1;
               end
            end else if (scl_fall && done_q) begin
               done_d   = 1'b0;
               sda_oe_d = ~I2C_ACK;
               state_d  = ST_WRITE_ACK;
            end
         end
         ST_WRITE_ACK: begin
            if (scl_fall) begin
               sda_oe_d  = 1'b0;
               bit_cnt_d = 3'd0;
               state_d   = ST_WRITE;
            end
         end
         ST_READ: begin
            if (scl_rise) begin
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) done_d = 1'b1;
            end else if (scl_fall) begin
               if (done_q) begin
                  done_d   = 1'b0;
                  sda_oe_d = 1'b0;
                  state_d  = ST_READ_ACK;
               end else begin
                  shift_d  = {shift_q[6:0], 1'b0};
                  sda_oe_d = ~shift_q[6];
               end
            end
         end
         ST_READ_ACK: begin
            // A NACK ends the read at the 9th rise; an ACK reloads on the 9th fall.
            if (scl_rise && (sda_s == I2C_NACK)) begin
               state_d    = ST_IGNORE;
               addr_hit_d = 1'b0;
            end else if (scl_fall) begin
               tx_req_c  = 1'b1;
               shift_d   = tx_data;
               sda_oe_d  = ~tx_data[7];
               bit_cnt_d = 3'd0;
               state_d   = ST_READ;
            end
         end
         ST_IGNORE: sda_oe_d = 1'b0;
         default: begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
         end
      endcase

      // Bus conditions override every state; a pending rx_valid strobe still fires.
      if (start_det) begin
         state_d    = ST_ADDR;
         bit_cnt_d  = 3'd0;
         done_d     = 1'b0;
         sda_oe_d   = 1'b0;
         addr_hit_d = 1'b0;
         busy_d     = 1'b1;
         tx_req_c   = 1'b0;
      end else if (stop_det) begin
         state_d    = ST_IDLE;
         done_d     = 1'b0;
         sda_oe_d   = 1'b0;
         addr_hit_d = 1'b0;
         busy_d     = 1'b0;
         tx_req_c   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= ST_IDLE;
         shift_q    <= 8'h00;
         bit_cnt_q  <= 3'd0;
         done_q     <= 1'b0;
         rw_q       <= RW_WRITE;
         sda_oe_q   <= 1'b0;
         addr_hit_q <= 1'b0;
         busy_q     <= 1'b0;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         done_q     <= done_d;
         rw_q       <= rw_d;
         sda_oe_q   <= sda_oe_d;
         addr_hit_q <= addr_hit_d;
         busy_q     <= busy_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
      end
   end

   assign sda      = sda_oe_q ? 1'b0 : 1'bz;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign tx_req   = tx_req_c;
   assign addr_hit = addr_hit_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: behavioural bus master with pullup, scoreboard queue
// for received bytes, directed write/read/abort/reset sequences.
import i2c_pkg::*;

module tb_i2c_target;

   localparam int HP = 8;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       m_scl = 1'b1;
   logic       m_sda_oe = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic [7:0] rx_data;
   logic       rx_valid, tx_req, addr_hit, busy;
   wire        sda;

   pullup (sda);
   assign sda = m_sda_oe ? 1'b0 : 1'bz;

   always #5 clk = ~clk;

   i2c_target #(.SLAVE_ADDR(7'h54), .SYNC_STAGES(2)) dut (
      .clk      (clk),
      .n_rst    (n_rst),
      .scl      (m_scl),
      .sda      (sda),
      .tx_data  (tx_data),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_req   (tx_req),
      .addr_hit (addr_hit),
      .busy     (busy)
   );

   int         tests = 0;
   int         fails = 0;
   logic [7:0] exp_q[$];
   logic [7:0] tx_src_q[$];
   int         rx_cnt = 0;
   int         tx_cnt = 0;
   bit         dut_low_seen = 1'b0;
   bit         hit_seen = 1'b0;
   bit         oe_bad = 1'b0;

   function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endfunction

   // Scoreboard monitor: every rx_valid pops one expected byte.
   always @(negedge clk) begin
      if (rx_valid) begin
         rx_cnt++;
         check("rx_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
      end
      if (!m_sda_oe && sda === 1'b0) dut_low_seen = 1'b1;
      if (addr_hit) hit_seen = 1'b1;
      if (dut.sda_oe_q && sda !== 1'b0) oe_bad = 1'b1;
   end

   // Local-side responder: after each tx_req present the next queued read byte.
   always @(negedge clk) begin
      if (tx_req) begin
         tx_cnt++;
         @(posedge clk);
         #1;
         if (tx_src_q.size() != 0) tx_data = tx_src_q.pop_front();
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_start();
      if (!m_scl) begin
         wait_clk(2);
         m_sda_oe = 1'b0;
         wait_clk(HP - 2);
         m_scl = 1'b1;
         wait_clk(HP);
      end
      m_sda_oe = 1'b1;
      wait_clk(HP);
      m_scl = 1'b0;
   endtask

   task automatic bus_stop();
      wait_clk(2);
      m_sda_oe = 1'b1;
      wait_clk(HP - 2);
      m_scl = 1'b1;
      wait_clk(HP);
      m_sda_oe = 1'b0;
      wait_clk(HP);
   endtask

   task automatic put_bit(input logic b);
      wait_clk(2);
      m_sda_oe = ~b;
      wait_clk(HP - 2);
      m_scl = 1'b1;
      wait_clk(HP);
      m_scl = 1'b0;
   endtask

   task automatic get_bit(output logic b);
      wait_clk(2);
      m_sda_oe = 1'b0;
      wait_clk(HP - 2);
      m_scl = 1'b1;
      wait_clk(HP / 2);
      b = sda;
      wait_clk(HP / 2);
      m_scl = 1'b0;
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) put_bit(d[i]);
      get_bit(ack);
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] d);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         get_bit(b);
         d[i] = b;
      end
      put_bit(mack);
   endtask

   initial begin
      logic       ack;
      logic [7:0] d;
      logic [7:0] wbytes [3];
      int         r0, t0;
      wbytes[0] = 8'h01;
      wbytes[1] = 8'h02;
      wbytes[2] = 8'h03;

      wait_clk(5);
      n_rst = 1'b1;
      wait_clk(5);
      check("reset_rx_data", 32'(rx_data), 32'h00);
      check("reset_rx_valid", 32'(rx_valid), 32'd0);
      check("reset_tx_req", 32'(tx_req), 32'd0);
      check("reset_addr_hit", 32'(addr_hit), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_sda", 32'(sda), 32'd1);
      check("reset_state", 32'(dut.state_q), 32'(ST_IDLE));
      check("reset_bit_cnt", 32'(dut.bit_cnt_q), 32'd0);

      // 1: single write
      r0 = rx_cnt;
      exp_q.push_back(8'h3C);
      bus_start();
      check("t1_busy_start", 32'(busy), 32'd1);
      write_byte(8'hA8, ack);
      check("t1_addr_ack", 32'(ack), 32'(I2C_ACK));
      check("t1_addr_hit", 32'(addr_hit), 32'd1);
      write_byte(8'h3C, ack);
      check("t1_data_ack", 32'(ack), 32'(I2C_ACK));
      bus_stop();
      check("t1_busy_stop", 32'(busy), 32'd0);
      check("t1_addr_hit_stop", 32'(addr_hit), 32'd0);
      check("t1_rx_count", 32'(rx_cnt - r0), 32'd1);

      // 2: address miss
      r0 = rx_cnt;
      t0 = tx_cnt;
      dut_low_seen = 1'b0;
      hit_seen = 1'b0;
      bus_start();
      write_byte(8'hAA, ack);
      check("t2_addr_nack", 32'(ack), 32'(I2C_NACK));
      write_byte(8'hFF, ack);
      check("t2_data_nack", 32'(ack), 32'(I2C_NACK));
      bus_stop();
      check("t2_sda_never_driven", 32'(dut_low_seen), 32'd0);
      check("t2_addr_hit_never", 32'(hit_seen), 32'd0);
      check("t2_rx_count", 32'(rx_cnt - r0), 32'd0);
      check("t2_tx_count", 32'(tx_cnt - t0), 32'd0);

      // 3: read two bytes, ACK then NACK
      t0 = tx_cnt;
      tx_data = 8'hC9;
      tx_src_q.push_back(8'h5A);
      bus_start();
      write_byte(8'hA9, ack);
      check("t3_addr_ack", 32'(ack), 32'(I2C_ACK));
      read_byte(I2C_ACK, d);
      check("t3_byte1", 32'(d), 32'hC9);
      read_byte(I2C_NACK, d);
      check("t3_byte2", 32'(d), 32'h5A);
      wait_clk(4);
      check("t3_state_ignore", 32'(dut.state_q), 32'(ST_IGNORE));
      check("t3_addr_hit_nack", 32'(addr_hit), 32'd0);
      check("t3_sda_released", 32'(sda), 32'd1);
      bus_stop();
      check("t3_tx_count", 32'(tx_cnt - t0), 32'd2);

      // 4: write then repeated START into a read
      r0 = rx_cnt;
      t0 = tx_cnt;
      exp_q.push_back(8'h11);
      tx_data = 8'h77;
      bus_start();
      write_byte(8'hA8, ack);
      write_byte(8'h11, ack);
      check("t4_data_ack", 32'(ack), 32'(I2C_ACK));
      bus_start();
      check("t4_busy_rs", 32'(busy), 32'd1);
      write_byte(8'hA9, ack);
      check("t4_addr_ack", 32'(ack), 32'(I2C_ACK));
      read_byte(I2C_NACK, d);
      check("t4_read_byte", 32'(d), 32'h77);
      bus_stop();
      check("t4_rx_count", 32'(rx_cnt - r0), 32'd1);
      check("t4_tx_count", 32'(tx_cnt - t0), 32'd1);

      // 5: STOP after four data bits, then reset during address ACK
      r0 = rx_cnt;
      bus_start();
      write_byte(8'hA8, ack);
      put_bit(1'b1);
      put_bit(1'b0);
      put_bit(1'b1);
      put_bit(1'b0);
      bus_stop();
      check("t5_abort_rx_count", 32'(rx_cnt - r0), 32'd0);
      check("t5_abort_state", 32'(dut.state_q), 32'(ST_IDLE));
      check("t5_abort_busy", 32'(busy), 32'd0);
      bus_start();
      for (int i = 7; i >= 0; i--) put_bit(r0[0] ? 1'b0 : 1'b0 | ((8'hA8 >> i) & 8'h01) != 8'h00);
      wait_clk(2);
      m_sda_oe = 1'b0;
      wait_clk(4);
      check("t5_ack_driven", 32'(sda), 32'd0);
      n_rst = 1'b0;
      #1;
      check("t5_reset_release", 32'(sda), 32'd1);
      check("t5_reset_busy", 32'(busy), 32'd0);
      wait_clk(3);
      n_rst = 1'b1;
      wait_clk(3);
      check("t5_reset_state", 32'(dut.state_q), 32'(ST_IDLE));
      bus_stop();

      // 6: three-byte write with bit counter wrap
      r0 = rx_cnt;
      foreach (wbytes[k]) exp_q.push_back(wbytes[k]);
      bus_start();
      write_byte(8'hA8, ack);
      check("t6_addr_ack", 32'(ack), 32'(I2C_ACK));
      foreach (wbytes[k]) begin
         for (int i = 7; i >= 0; i--) begin
            put_bit(wbytes[k][i]);
            if (i == 1) check("t6_bit_cnt_7", 32'(dut.bit_cnt_q), 32'd7);
         end
         check("t6_bit_cnt_wrap", 32'(dut.bit_cnt_q), 32'd0);
         get_bit(ack);
         check("t6_data_ack", 32'(ack), 32'(I2C_ACK));
      end
      bus_stop();
      check("t6_rx_count", 32'(rx_cnt - r0), 32'd3);

      wait_clk(10);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      check("sda_only_driven_low", 32'(oe_bad), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
